ifu_fetch: RTL and testbench

Instruction fetch stage of the multi-cycle RV32E NPC. It sits directly upstream of the decode stage. It holds the architectural PC and issues one instruction read at a time on an AXI4-Lite-style AR/R channel. The fetched word and its PC go to decode over a valid/ready handshake. After handoff the block stalls until writeback commits the next PC.

---
 rtl/ifu_fetch_pkg.sv | 17 +
 rtl/ifu_fetch.sv | 95 +++++++++
 tb/tb_ifu_fetch.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared constants for the RV32E instruction fetch stage: FSM state
// encoding, bus response codes, fault causes and the default reset PC.
package ifu_fetch_pkg;

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_WAIT_R  = 2'd1;
  localparam logic [1:0] S_OUT     = 2'd2;
  localparam logic [1:0] S_WAIT_PC = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic FC_MISALIGN = 1'b0;
  localparam logic FC_BUSERR   = 1'b1;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage of the multi-cycle RV32E NPC. Holds the PC,
// issues one AR/R read at a time, hands the word to decode and then
// waits for writeback to commit the next PC before fetching again.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ar_valid,
  input  logic             ar_ready,
  output logic [31:0]      ar_addr,
  input  logic             r_valid,
  output logic             r_ready,
  input  logic [31:0]      r_data,
  input  logic [1:0]       r_resp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic [31:0]      pc_o,
  output logic             fault,
  output logic             fault_cause,
  input  logic             pc_wen,
  input  logic [31:0]      pc_next,
  output logic [CNT_W-1:0] fetch_cnt
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] pc;
  logic        pc_aligned;

  assign pc_aligned = (pc[1:0] == 2'b00);

  // Handshake outputs are pure functions of state; rst gating keeps them
  // low for the whole time reset is held, not just after the first edge.
  assign ar_valid  = rst && (state == S_REQ) && pc_aligned;
  assign r_ready   = rst && (state == S_WAIT_R);
  assign out_valid = rst && (state == S_OUT);
  assign ar_addr   = pc;
  assign pc_o      = pc;

  // Next-state logic; a misaligned PC skips the bus entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (!pc_aligned)            state_nxt = S_OUT;
        else if (ar_ready)          state_nxt = S_WAIT_R;
      end
      S_WAIT_R:  if (r_valid)       state_nxt = S_OUT;
      S_OUT:     if (out_ready)     state_nxt = S_WAIT_PC;
      S_WAIT_PC: if (pc_wen)        state_nxt = S_REQ;
      default:                      state_nxt = S_REQ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_REQ;
    else      state <= state_nxt;
  end

  // PC only moves when writeback commits while we are waiting for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               pc <= RESET_PC;
    else if ((state == S_WAIT_PC) && pc_wen) pc <= pc_next;
  end

  // Capture the instruction word and fault status handed to decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst        <= 32'h0;
      fault       <= 1'b0;
      fault_cause <= 1'b0;
    end else if ((state == S_REQ) && !pc_aligned) begin
      inst        <= 32'h0;
      fault       <= 1'b1;
      fault_cause <= FC_MISALIGN;
    end else if ((state == S_WAIT_R) && r_valid) begin
      inst        <= r_data;
      fault       <= (r_resp != RESP_OKAY);
      fault_cause <= FC_BUSERR;
    end
  end

  // Count instructions accepted by decode; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        fetch_cnt <= '0;
    else if (out_valid && out_ready) fetch_cnt <= fetch_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a small memory model answers reads,
// expected decode handoffs go through a scoreboard queue.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic        cause;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ar_valid, r_ready, out_valid, fault, fault_cause;
  logic        ar_ready = 1'b0, r_valid = 1'b0, out_ready = 1'b0, pc_wen = 1'b0;
  logic [31:0] ar_addr, inst, pc_o, fetch_cnt;
  logic [31:0] r_data = 32'h0, pc_next = 32'h0;
  logic [1:0]  r_resp = 2'b00;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  int          ar_hs = 0;
  int          bench_cnt = 0;
  logic [31:0] bench_pc = RST_PC;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .out_valid(out_valid), .out_ready(out_ready), .inst(inst), .pc_o(pc_o),
    .fault(fault), .fault_cause(fault_cause),
    .pc_wen(pc_wen), .pc_next(pc_next), .fetch_cnt(fetch_cnt)
  );

  // Count completed AR handshakes seen on the bus.
  always @(posedge clk) if (rst && ar_valid && ar_ready) ar_hs <= ar_hs + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0010_0073;
      32'h8000_0004: return 32'h0000_0013;
      32'h8000_0008: return 32'h1234_5678;
      32'h8000_000C: return 32'hFFC1_0113;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Memory side of one read: wait for AR, stall ar_ready, then return data.
  task automatic mem_fetch(input int ar_stall, input logic [1:0] resp,
                           output bit stable, output bit timeout);
    int n;
    logic [31:0] a0;
    exp_t e;
    stable = 1'b1; timeout = 1'b0; n = 0;
    while (ar_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (ar_valid !== 1'b1) begin timeout = 1'b1; return; end
    a0 = ar_addr;
    for (int i = 0; i < ar_stall; i++) begin
      @(negedge clk);
      if (ar_valid !== 1'b1 || ar_addr !== a0) stable = 1'b0;
    end
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    r_valid = 1'b1; r_data = mem_word(bench_pc); r_resp = resp;
    e.inst = mem_word(bench_pc); e.pc = bench_pc;
    e.fault = (resp != RESP_OKAY); e.cause = FC_BUSERR;
    sb.push_back(e);
    @(negedge clk);
    r_valid = 1'b0; r_resp = 2'b00;
  endtask

  task automatic wait_out(input int max, output int waited);
    waited = 0;
    while (out_valid !== 1'b1 && waited < max) begin @(negedge clk); waited++; end
  endtask

  // Decode side: hold out_ready low for `hold` cycles, then accept.
  task automatic handoff(input int hold, output bit stable);
    logic [65:0] snap;
    logic [31:0] cnt0;
    snap = {inst, pc_o, fault, fault_cause};
    cnt0 = fetch_cnt;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || {inst, pc_o, fault, fault_cause} !== snap ||
          fetch_cnt !== cnt0) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    bench_cnt++;
  endtask

  task automatic commit_pc(input logic [31:0] nxt);
    exp_t e;
    pc_wen = 1'b1; pc_next = nxt;
    @(negedge clk);
    pc_wen = 1'b0;
    bench_pc = nxt;
    if (nxt[1:0] != 2'b00) begin
      e.inst = 32'h0; e.pc = nxt; e.fault = 1'b1; e.cause = FC_MISALIGN;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({ar_valid, r_ready, out_valid} !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_handshakes: got %b want 000", {ar_valid, r_ready, out_valid});
    end
    checks++;
    if (pc_o !== RST_PC) begin
      fails++; $display("[TB] FAIL reset_pc: got %h want %h", pc_o, RST_PC);
    end
    checks++;
    if ({inst, fault, fault_cause} !== 34'h0) begin
      fails++; $display("[TB] FAIL reset_inst_fault: got %h/%b/%b want 0/0/0", inst, fault, fault_cause);
    end
    checks++;
    if (fetch_cnt !== 32'h0) begin
      fails++; $display("[TB] FAIL reset_cnt: got %0d want 0", fetch_cnt);
    end
  endtask

  task automatic test_first_fetch();
    bit st, to; int w; exp_t e;
    rst = 1'b1;
    #1;
    checks++;
    if (ar_valid !== 1'b1 || ar_addr !== RST_PC) begin
      fails++; $display("[TB] FAIL first_ar: got valid=%b addr=%h want 1/%h", ar_valid, ar_addr, RST_PC);
    end
    mem_fetch(0, RESP_OKAY, st, to);
    wait_out(0, w);
    checks++;
    if (to || out_valid !== 1'b1) begin
      fails++; $display("[TB] FAIL first_latency: got out_valid=%b timeout=%0d want 1/0", out_valid, to);
    end
    checks++;
    if (sb.size() == 0) begin
      fails++; $display("[TB] FAIL first_out: got empty scoreboard want one entry");
    end else begin
      e = sb.pop_front();
      if ({inst, pc_o, fault, fault_cause} !== e) begin
        fails++; $display("[TB] FAIL first_out: got %h want %h", {inst, pc_o, fault, fault_cause}, e);
      end
    end
    handoff(0, st);
    checks++;
    if (fetch_cnt !== 32'(bench_cnt) || out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL first_cnt: got cnt=%0d out_valid=%b want %0d/0", fetch_cnt, out_valid, bench_cnt);
    end
  endtask

  task automatic test_ar_stall();
    bit st, to; int w, hs0; exp_t e;
    commit_pc(32'h8000_0004);
    checks++;
    if (ar_valid !== 1'b1 || ar_addr !== 32'h8000_0004) begin
      fails++; $display("[TB] FAIL commit_ar: got valid=%b addr=%h want 1/80000004", ar_valid, ar_addr);
    end
    hs0 = ar_hs;
    mem_fetch(5, RESP_OKAY, st, to);
    checks++;
    if (!st || to) begin
      fails++; $display("[TB] FAIL ar_stall_stable: got stable=%0d timeout=%0d want 1/0", st, to);
    end
    checks++;
    if (ar_hs - hs0 != 1) begin
      fails++; $display("[TB] FAIL ar_stall_handshakes: got %0d want 1", ar_hs - hs0);
    end
    wait_out(0, w);
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      fails++; $display("[TB] FAIL ar_stall_out: got out_valid=%b queued=%0d want 1/1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if ({inst, pc_o, fault, fault_cause} !== e) begin
        fails++; $display("[TB] FAIL ar_stall_out: got %h want %h", {inst, pc_o, fault, fault_cause}, e);
      end
    end
    handoff(0, st);
  endtask

  task automatic test_out_stall();
    bit st, to; int w, hs0; exp_t e;
    commit_pc(32'h8000_0008);
    mem_fetch(0, RESP_OKAY, st, to);
    wait_out(5, w);
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      fails++; $display("[TB] FAIL out_stall_out: got out_valid=%b queued=%0d want 1/1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if ({inst, pc_o, fault, fault_cause} !== e) begin
        fails++; $display("[TB] FAIL out_stall_out: got %h want %h", {inst, pc_o, fault, fault_cause}, e);
      end
    end
    r_valid = 1'b1; r_data = 32'hBAD0_BAD0; r_resp = 2'b11;
    handoff(4, st);
    r_valid = 1'b0; r_resp = 2'b00;
    checks++;
    if (!st) begin
      fails++; $display("[TB] FAIL out_stall_hold: got outputs changing during stall want stable");
    end
    checks++;
    if (fetch_cnt !== 32'(bench_cnt)) begin
      fails++; $display("[TB] FAIL out_stall_cnt: got %0d want %0d", fetch_cnt, bench_cnt);
    end
    hs0 = ar_hs;
    ar_ready = 1'b1;
    w = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ar_valid !== 1'b0) w++;
    end
    ar_ready = 1'b0;
    checks++;
    if (w != 0 || ar_hs != hs0) begin
      fails++; $display("[TB] FAIL no_ar_before_pc_wen: got %0d ar_valid cycles, %0d handshakes want 0/0", w, ar_hs - hs0);
    end
  endtask

  task automatic test_pc_wen_ignored();
    bit st; exp_t e;
    commit_pc(32'h8000_000C);
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    pc_wen = 1'b1; pc_next = 32'h1234_5670;
    checks++;
    if (r_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL wait_r_ready: got %b want 1", r_ready);
    end
    @(negedge clk);
    pc_wen = 1'b0;
    checks++;
    if (pc_o !== bench_pc) begin
      fails++; $display("[TB] FAIL pc_wen_ignored: got pc %h want %h", pc_o, bench_pc);
    end
    r_valid = 1'b1; r_data = mem_word(bench_pc); r_resp = RESP_OKAY;
    e.inst = mem_word(bench_pc); e.pc = bench_pc; e.fault = 1'b0; e.cause = FC_BUSERR;
    sb.push_back(e);
    @(negedge clk);
    r_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      fails++; $display("[TB] FAIL late_r_out: got out_valid=%b queued=%0d want 1/1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if ({inst, pc_o, fault, fault_cause} !== e) begin
        fails++; $display("[TB] FAIL late_r_out: got %h want %h", {inst, pc_o, fault, fault_cause}, e);
      end
    end
    handoff(0, st);
  endtask

  task automatic test_bus_error();
    bit st, to; int w, hs0; exp_t e;
    commit_pc(32'h8000_0010);
    mem_fetch(0, 2'b10, st, to);
    wait_out(5, w);
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      fails++; $display("[TB] FAIL bus_error_out: got out_valid=%b queued=%0d want 1/1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if ({inst, pc_o, fault, fault_cause} !== e) begin
        fails++; $display("[TB] FAIL bus_error_out: got %h want %h", {inst, pc_o, fault, fault_cause}, e);
      end
    end
    handoff(0, st);
    hs0 = ar_hs;
    ar_ready = 1'b1;
    commit_pc(32'h8000_0002);
    checks++;
    if (ar_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL misalign_no_ar: got ar_valid=%b want 0", ar_valid);
    end
    @(negedge clk);
    ar_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0 || ar_hs != hs0) begin
      fails++; $display("[TB] FAIL misalign_out: got out_valid=%b queued=%0d hs=%0d want 1/1/0", out_valid, sb.size(), ar_hs - hs0);
    end else begin
      e = sb.pop_front();
      if ({inst, pc_o, fault, fault_cause} !== e) begin
        fails++; $display("[TB] FAIL misalign_out: got %h want %h", {inst, pc_o, fault, fault_cause}, e);
      end
    end
    handoff(0, st);
    checks++;
    if (fetch_cnt !== 32'(bench_cnt)) begin
      fails++; $display("[TB] FAIL misalign_cnt: got %0d want %0d", fetch_cnt, bench_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit st, to; int w; exp_t e;
    commit_pc(32'h8000_0004);
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    checks++;
    if (r_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL mid_wait_r: got r_ready=%b want 1", r_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ar_valid, r_ready, out_valid} !== 3'b000) begin
      fails++; $display("[TB] FAIL mid_reset_drop: got %b want 000", {ar_valid, r_ready, out_valid});
    end
    checks++;
    if (pc_o !== RST_PC || fetch_cnt !== 32'h0) begin
      fails++; $display("[TB] FAIL mid_reset_state: got pc=%h cnt=%0d want %h/0", pc_o, fetch_cnt, RST_PC);
    end
    sb.delete();
    bench_cnt = 0;
    bench_pc = RST_PC;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ar_valid !== 1'b1 || ar_addr !== RST_PC) begin
      fails++; $display("[TB] FAIL restart_ar: got valid=%b addr=%h want 1/%h", ar_valid, ar_addr, RST_PC);
    end
    mem_fetch(0, RESP_OKAY, st, to);
    wait_out(5, w);
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      fails++; $display("[TB] FAIL restart_out: got out_valid=%b queued=%0d want 1/1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if ({inst, pc_o, fault, fault_cause} !== e) begin
        fails++; $display("[TB] FAIL restart_out: got %h want %h", {inst, pc_o, fault, fault_cause}, e);
      end
    end
    handoff(0, st);
    checks++;
    if (fetch_cnt !== 32'(bench_cnt)) begin
      fails++; $display("[TB] FAIL restart_cnt: got %0d want %0d", fetch_cnt, bench_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_ar_stall();
    test_out_stall();
    test_pc_wen_ignored();
    test_bus_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
